serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus carry flop, LSB first
// Ports:
//   clk    - clock, all state updates on rising edge
//   reset  - synchronous active-high reset
//   start  - load request, accepted only in IDLE or DONE
//   a, b   - WIDTH-bit unsigned operands, captured on accepted start
//   ci     - carry-in, captured on accepted start
//   busy   - high while bits are being shifted through the adder cell
//   done   - one-cycle pulse when s/co hold a fresh result
//   s, co  - registered sum and carry-out, held until the next accepted start
//   ovf    - two's-complement overflow flag, only with SERIAL_ADDER_OVF_EN defined
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, s_q, s_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q, co_q, busy_q, done_q;
    logic             s_bit, co_bit, last, load;
    fa u_fa (.a(sa_q[0]), .b(sb_q[0]), .ci(c_q), .s(s_bit), .co(co_bit));
    assign s_d  = {s_bit, s_q[WIDTH-1:1]};
    assign last = cnt_q == CW'(WIDTH - 1);
    // IDLE and DONE both accept a start, which is what makes back-to-back work
    assign load = start && state_q != RUN;
`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
    // carry into MSB is c_q before its update, carry out of MSB is co_bit
    always_ff @(posedge clk) begin
        if (reset || load)
            ovf_q <= 1'b0;
        else if (state_q == RUN && last)
            ovf_q <= c_q ^ co_bit;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
        end else if (state_q == RUN) begin
            s_q   <= s_d;
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            c_q   <= co_bit;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                co_q    <= co_bit;
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
            if (load) begin
                sa_q    <= a;
                sb_q    <= b;
                c_q     <= ci;
                cnt_q   <= '0;
                s_q     <= '0;
                co_q    <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= RUN;
            end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
            end
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=4
module tb_serial_adder;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         reset, start, ci;
    logic [W-1:0] a, b, s;
    logic         busy, done, co, ovf_w;
    logic [5:0]   exq[$];
    int           n_cmp = 0;
    int           n_err = 0;
    always #5 clk = ~clk;
    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_w)
`endif
    );
`ifndef SERIAL_ADDER_OVF_EN
    assign ovf_w = 1'b0;
`endif
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                logic [5:0] e;
                e = exq.pop_front();
                chk("sum", {co, s}, e[4:0]);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", ovf_w, e[5]);
`endif
            end
        end
    end
    function automatic logic [5:0] ref_sum(input logic [W-1:0] av, bv, input logic cv);
        logic [W:0] r;
        r = av + bv + cv;
        return {(av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]), r};
    endfunction
    task automatic op(input logic [W-1:0] av, bv, input logic cv, input logic [5:0] ex);
        int t, bc;
        @(negedge clk);
        a = av; b = bv; ci = cv; start = 1'b1;
        exq.push_back(ex);
        @(negedge clk);
        start = 1'b0;
        t = 0; bc = 0;
        while (done !== 1'b1 && t < 20) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            t++;
        end
        chk("done_latency", t + 1, W + 1);
        chk("busy_cycles", bc, W);
    endtask
    initial begin
        logic [W-1:0] nxa, nxb;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", ovf_w, 0);
        op(4'd3, 4'd5, 1'b0, 6'b1_0_1000);
        repeat (3) @(negedge clk);
        chk("hold_s", s, 8);
        chk("hold_co", co, 0);
        chk("hold_done", done, 0);
        op(4'd15, 4'd1, 1'b0, 6'b0_1_0000);
        op(4'd15, 4'd15, 1'b1, 6'b0_1_1111);
        for (int i = 0; i < 512; i++)
            op(i[3:0], i[7:4], i[8], ref_sum(i[3:0], i[7:4], i[8]));
        // start held high: RUN cycles see junk operands, only DONE cycles present real ones
        @(negedge clk);
        a = 4'd7; b = 4'd9; ci = 1'b0; start = 1'b1;
        exq.push_back(ref_sum(4'd7, 4'd9, 1'b0));
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j <= W; j++) begin
                @(negedge clk);
                chk("b2b_done", done, j == W);
                if (j < W) begin
                    a = 4'(j * 5 + 1); b = 4'(j * 3 + 2); ci = j[0];
                end else if (k < 2) begin
                    nxa = 4'(k * 6 + 2); nxb = 4'(13 - k);
                    a = nxa; b = nxb; ci = 1'b1;
                    exq.push_back(ref_sum(nxa, nxb, 1'b1));
                end else begin
                    start = 1'b0;
                end
            end
        end
        repeat (2) @(negedge clk);
        a = 4'd7; b = 4'd9; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_s", s, 0);
        chk("midrst_co", co, 0);
        repeat (6) @(negedge clk);
        op(4'd7, 4'd9, 1'b0, 6'b0_1_0000);
        repeat (3) @(negedge clk);
        chk("queue_empty", exq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
